// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Multi-cycle integer divider serving DIV (signed) and DIVU (unsigned) from
//   the EX stage. Radix-2 restoring division, one quotient bit per clock,
//   MSB first. Signed operands are divided as magnitudes, and the signs are
//   applied to the quotient and remainder at the end.
//
//   Handshake: EX raises start_i with the operands and holds it until it sees
//   ready_o. The result is held while start_i stays high. Dropping start_i
//   returns the unit to idle. annul_i aborts any in-flight or completed
//   division.
//
// Ports
//   clk           in   1        clock, rising edge
//   rst           in   1        asynchronous, active-low reset
//   signed_div_i  in   1        1: two's-complement divide, 0: unsigned
//   opdata1_i     in   WIDTH    dividend, sampled only when leaving FREE
//   opdata2_i     in   WIDTH    divisor, sampled only when leaving FREE
//   start_i       in   1        request, held high until ready_o
//   annul_i       in   1        abort current/pending division
//   result_o      out  2*WIDTH  {remainder, quotient}, valid while ready_o=1
//   ready_o       out  1        result valid (registered)
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  // Iteration state. r_quot starts out holding |dividend|. Each step shifts
  // one dividend bit out of the top and one quotient bit in at the bottom,
  // so after WIDTH steps it holds only the quotient.
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_neg_quot;
  logic               r_neg_rem;

  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  // ---------------------------------------------------------------------------
  // Operand capture: magnitudes and result signs
  // ---------------------------------------------------------------------------
  logic               w_op1_neg;
  logic               w_op2_neg;
  logic [WIDTH-1:0]   w_abs_op1;
  logic [WIDTH-1:0]   w_abs_op2;
  logic               w_launch;
  logic               w_div_zero;

  assign w_op1_neg  = signed_div_i & opdata1_i[WIDTH-1];
  assign w_op2_neg  = signed_div_i & opdata2_i[WIDTH-1];
  // The most negative value maps to itself, and as an unsigned magnitude that
  // is the correct |x|.
  assign w_abs_op1  = w_op1_neg ? (-opdata1_i) : opdata1_i;
  assign w_abs_op2  = w_op2_neg ? (-opdata2_i) : opdata2_i;
  assign w_launch   = start_i & ~annul_i;
  assign w_div_zero = (opdata2_i == '0);

  // ---------------------------------------------------------------------------
  // One restoring step
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_borrow;
  logic               w_iter_done;

  // The partial remainder is always below the divisor. After shifting it can
  // need WIDTH+1 bits, so the trial subtraction gets one more guard bit. That
  // top bit is the borrow.
  assign w_shift     = {r_rem, r_quot[WIDTH-1]};
  assign w_diff      = {1'b0, w_shift} - {2'b00, r_divisor};
  assign w_borrow    = w_diff[WIDTH+1];
  assign w_iter_done = (r_cnt == CNT_W'(WIDTH));

  // ---------------------------------------------------------------------------
  // Sign fixup applied on the final edge
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_quot_fix = r_neg_quot ? (-r_quot) : r_quot;
  assign w_rem_fix  = r_neg_rem  ? (-r_rem)  : r_rem;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: w_next gets its default before the case statement. Every path then
  // assigns it, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FREE: begin
        if (w_launch) begin
          w_next = w_div_zero ? S_BY_ZERO : S_ON;
        end
      end
      S_BY_ZERO: begin
        w_next = annul_i ? S_FREE : S_END;
      end
      S_ON: begin
        if (annul_i) begin
          w_next = S_FREE;
        end else if (w_iter_done) begin
          w_next = S_END;
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          w_next = S_FREE;
        end
      end
      default: w_next = S_FREE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and datapath
  // ---------------------------------------------------------------------------
  // NOTE: all state uses non-blocking assignments. Every register then reads
  // its pre-edge value, regardless of the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FREE;
      r_cnt      <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_neg_quot <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_FREE: begin
          r_ready  <= 1'b0;
          r_result <= '0;
          if (w_launch && !w_div_zero) begin
            r_quot     <= w_abs_op1;
            r_divisor  <= w_abs_op2;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_neg_quot <= w_op1_neg ^ w_op2_neg;
            r_neg_rem  <= w_op1_neg;
          end
        end

        S_BY_ZERO: begin
          // A zero divisor produces an all-zero result and no exception.
          r_result <= '0;
          r_ready  <= ~annul_i;
        end

        S_ON: begin
          if (annul_i) begin
            r_ready  <= 1'b0;
            r_result <= '0;
          end else if (w_iter_done) begin
            r_result <= {w_rem_fix, w_quot_fix};
            r_ready  <= 1'b1;
          end else begin
            // Without a borrow the trial difference fits in WIDTH bits. With a
            // borrow the shifted remainder is below the divisor, so it also
            // fits.
            r_rem  <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_quot <= {r_quot[WIDTH-2:0], ~w_borrow};
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end

        S_END: begin
          if (annul_i || !start_i) begin
            r_ready  <= 1'b0;
            r_result <= '0;
          end
        end

        default: begin
          r_ready  <= 1'b0;
          r_result <= '0;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Scoreboard bench for div_unit.
//   - The stimulus tasks push the expected result and latency for each
//     division they issue.
//   - The monitor pops and compares on every rising edge of ready_o.
//   - Expected values come from plain integer '/' and '%' on 64-bit values,
//     which truncate toward zero, as DIV/DIVU do.
// -----------------------------------------------------------------------------
module tb_div_unit;

  localparam int W = 32;

  logic           clk          = 1'b0;
  logic           rst          = 1'b0;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i    = '0;
  logic [W-1:0]   opdata2_i    = '0;
  logic           start_i      = 1'b0;
  logic           annul_i      = 1'b0;
  logic [2*W-1:0] result_o;
  logic           ready_o;

  typedef struct {
    logic [63:0] result;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   cyc        = 0;
  logic prev_ready = 1'b0;

  div_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: each new rising of ready_o must match the oldest outstanding
  // division, both in value and in latency from the edge that sampled start_i.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (ready_o && !prev_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got result %h, expected no pending result", result_o);
      end else begin
        e = sb_q.pop_front();
        check("result", result_o, e.result);
        check("latency", 64'(cyc - e.issue), 64'(e.lat));
      end
    end
    prev_ready <= ready_o;
  end

  // One division, with start_i held until ready_o is seen. With scramble set,
  // the operands are changed after capture. With hold_reset set, the result is
  // held for a few cycles and then cleared by an asynchronous reset between
  // clock edges.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input bit hold_reset);
    exp_t e;
    int   n;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    e.result     = model(sgn, a, b);
    e.lat        = (b == 32'd0) ? 2 : 34;
    e.issue      = cyc;
    sb_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (scramble) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
      end
    end while (!ready_o && n < 100);
    check("ready_seen", 64'(ready_o), 64'd1);
    if (!ready_o) begin
      start_i = 1'b0;
      return;
    end
    if (hold_reset) begin
      repeat (3) begin
        @(negedge clk);
        check("hold_ready", 64'(ready_o), 64'd1);
        check("hold_result", result_o, e.result);
      end
      #2 rst = 1'b0;
      #1;
      check("async_rst_ready", 64'(ready_o), 64'd0);
      check("async_rst_result", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end else begin
      start_i = 1'b0;
      @(negedge clk);
      check("drop_ready", 64'(ready_o), 64'd0);
      check("drop_result", result_o, 64'd0);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b1;

    // Directed cases
    run_op(1'b0, 32'd100,        32'd7,        1'b0, 1'b0);
    run_op(1'b1, 32'hFFFFFFF9,   32'h2,        1'b1, 1'b0);
    run_op(1'b1, 32'd7,          32'hFFFFFFFE, 1'b0, 1'b0);
    run_op(1'b0, 32'h12345678,   32'd0,        1'b1, 1'b0);
    run_op(1'b1, 32'h80000001,   32'd0,        1'b0, 1'b0);
    run_op(1'b1, 32'h80000000,   32'hFFFFFFFF, 1'b0, 1'b0);
    run_op(1'b0, 32'hFFFFFFFF,   32'd1,        1'b0, 1'b0);
    run_op(1'b0, 32'd5,          32'hFFFFFFFF, 1'b0, 1'b0);

    // Annul at cnt=10, followed immediately by a new DIVU 9/3. A result
    // from the aborted division would reach the monitor as a bad pop.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_ready", 64'(ready_o), 64'd0);
    run_op(1'b0, 32'd9, 32'd3, 1'b0, 1'b0);

    // start_i and annul_i together in FREE: the unit stays idle. The divisor
    // is zero, so a wrongly accepted start would show ready within 2 edges.
    @(negedge clk);
    opdata1_i = 32'd50;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("start_annul_ready", 64'(ready_o), 64'd0);
    end
    start_i = 1'b0;
    annul_i = 1'b0;

    // Asynchronous reset in the middle of ON, then recovery.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd777;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_on_rst_ready", 64'(ready_o), 64'd0);
    check("mid_on_rst_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, 1'b0, 1'b0);

    // Result held in END, then cleared by an asynchronous reset.
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1, 1'b1);

    // Randomized operands, with small and zero divisors mixed in.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      int          sel;
      a   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0)      b = 32'd0;
      else if (sel == 1) b = 32'($urandom_range(1, 15));
      else if (sel == 2) b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
      else               b = $urandom;
      run_op(1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
